// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter: register file
// geometry, default data width and the conventional write-back source slots.
package rf_write_arbiter_pkg;

   localparam int REG_CNT        = 8;
   localparam int REG_SEL_W      = 3;
   localparam int DEFAULT_DATA_W = 16;

   localparam int SRC_ALU  = 0;
   localparam int SRC_MEM  = 1;
   localparam int SRC_LINK = 2;
   localparam int SRC_TRAP = 3;

endpackage

// File: rtl/rf_write_arbiter_demux8.sv
// 3-to-8 decoder producing a one-hot register select from a binary index.
module demux8
   import rf_write_arbiter_pkg::*;
(
   input  logic [REG_SEL_W-1:0] select_input,
   output logic [REG_CNT-1:0]   data_output
);

   always_comb begin
      data_output               = '0;
      data_output[select_input] = 1'b1;
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between write-back
// sources, with a one-entry registered output stage.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = DEFAULT_DATA_W
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_SRC-1:0]          src_valid,
   input  logic [NUM_SRC*REG_SEL_W-1:0] src_dest,
   input  logic [NUM_SRC*DATA_W-1:0]   src_data,
   output logic [NUM_SRC-1:0]          src_ready,
   input  logic                        rf_hold,
   output logic                        rf_we,
   output logic [REG_SEL_W-1:0]        rf_sel,
   output logic [DATA_W-1:0]           rf_wdata,
   output logic [REG_CNT-1:0]          rf_wen
);

   localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   // Handshake: a source transfers in a cycle where src_valid[i] & src_ready[i];
   // src_valid must not depend on src_ready, and dest/data stay stable until granted.
   logic                  out_valid;
   logic [REG_SEL_W-1:0]  out_sel;
   logic [DATA_W-1:0]     out_data;
   logic [PTR_W-1:0]      rr_ptr;

   logic                  can_accept;
   logic                  grant_any;
   logic [PTR_W-1:0]      grant_idx;
   logic [PTR_W-1:0]      scan_idx;
   logic [NUM_SRC-1:0]    grant;
   logic [PTR_W-1:0]      next_ptr;
   logic [REG_CNT-1:0]    sel_onehot;

   logic [REG_SEL_W-1:0]  dest_arr [NUM_SRC];
   logic [DATA_W-1:0]     data_arr [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
      assign dest_arr[i] = src_dest[i*REG_SEL_W +: REG_SEL_W];
      assign data_arr[i] = src_data[i*DATA_W +: DATA_W];
   end

   // The stage can take a new write when empty or when its current write drains now.
   assign can_accept = ~out_valid | ~rf_hold;

   always_comb begin
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      scan_idx  = '0;
      if (!reset && can_accept) begin
         for (int k = 0; k < NUM_SRC; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_SRC);
            if (!grant_any && src_valid[scan_idx]) begin
               grant[scan_idx] = 1'b1;
               grant_any       = 1'b1;
               grant_idx       = scan_idx;
            end
         end
      end
   end

   assign src_ready = grant;
   assign next_ptr  = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_sel   <= '0;
         out_data  <= '0;
         rr_ptr    <= '0;
      end else if (grant_any) begin
         out_valid <= 1'b1;
         out_sel   <= dest_arr[grant_idx];
         out_data  <= data_arr[grant_idx];
         rr_ptr    <= next_ptr;
      end else if (!rf_hold) begin
         out_valid <= 1'b0;
      end
   end

   demux8 u_demux8 (
      .select_input (out_sel),
      .data_output  (sel_onehot)
   );

   assign rf_we    = out_valid;
   assign rf_sel   = out_sel;
   assign rf_wdata = out_data;
   assign rf_wen   = sel_onehot & {REG_CNT{out_valid}};

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: grants are checked as issued, completed
// register writes are checked against an expected queue by a separate monitor.
module tb_rf_write_arbiter;
   import rf_write_arbiter_pkg::*;

   localparam int NUM_SRC = 4;
   localparam int DATA_W  = 16;

   logic                      clk;
   logic                      reset;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC*3-1:0]      src_dest;
   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [NUM_SRC-1:0]        src_ready;
   logic                      rf_hold;
   logic                      rf_we;
   logic [2:0]                rf_sel;
   logic [DATA_W-1:0]         rf_wdata;
   logic [7:0]                rf_wen;

   logic [2:0]        dest_a [NUM_SRC];
   logic [DATA_W-1:0] data_a [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_pack
      assign src_dest[3*i +: 3]           = dest_a[i];
      assign src_data[DATA_W*i +: DATA_W] = data_a[i];
   end

   rf_write_arbiter #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .src_valid (src_valid),
      .src_dest  (src_dest),
      .src_data  (src_data),
      .src_ready (src_ready),
      .rf_hold   (rf_hold),
      .rf_we     (rf_we),
      .rf_sel    (rf_sel),
      .rf_wdata  (rf_wdata),
      .rf_wen    (rf_wen)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [26:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard monitor: every completed write must match the oldest expected one
   always @(negedge clk) begin
      if (!reset && rf_we === 1'b1 && rf_hold === 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got sel=%0d data=0x%0h wen=0x%0h with nothing expected",
                     rf_sel, rf_wdata, rf_wen);
         end else begin
            logic [26:0] e;
            e = exp_q.pop_front();
            if ({rf_sel, rf_wdata, rf_wen} !== e) begin
               errors++;
               $display("FAIL write: got sel=%0d data=0x%0h wen=0x%0h expected sel=%0d data=0x%0h wen=0x%0h",
                        rf_sel, rf_wdata, rf_wen, e[26:24], e[23:8], e[7:0]);
            end
         end
      end
   end

   // driver tasks
   task automatic drive(input logic [3:0] v, input logic hold);
      src_valid = v;
      rf_hold   = hold;
   endtask

   task automatic set_src(input int i, input logic [2:0] d, input logic [15:0] x);
      dest_a[i] = d;
      data_a[i] = x;
   endtask

   // Waits to the negedge, checks the grant and queues the write it implies.
   task automatic grant_check(input string name, input logic [3:0] exp_ready, input bit push);
      logic [7:0] oh;
      @(negedge clk);
      chk(name, 32'(src_ready), 32'(exp_ready));
      if (push) begin
         for (int g = 0; g < NUM_SRC; g++) begin
            if (exp_ready[g]) begin
               oh = 8'b1 << dest_a[g];
               exp_q.push_back({dest_a[g], data_a[g], oh});
            end
         end
      end
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1;
      drive(4'b1111, 1'b0);
      set_src(SRC_ALU,  3'd1, 16'h1111);
      set_src(SRC_MEM,  3'd5, 16'hBEEF);
      set_src(SRC_LINK, 3'd2, 16'h2222);
      set_src(SRC_TRAP, 3'd6, 16'h6666);
      advance();

      // reset with every source requesting
      for (int c = 0; c < 2; c++) begin
         grant_check("reset_ready", 4'b0000, 0);
         chk("reset_rf_we", 32'(rf_we), 32'd0);
         chk("reset_rf_wen", 32'(rf_wen), 32'h00);
         chk("reset_rf_sel", 32'(rf_sel), 32'd0);
         advance();
      end
      reset = 1'b0;
      grant_check("first_grant_src0", 4'b0001, 1);
      advance();

      // single request from source 1 (rr_ptr = 1)
      drive(4'b0010, 1'b0);
      grant_check("single_ready", 4'b0010, 1);
      advance();
      drive(4'b0000, 1'b0);
      @(negedge clk);
      chk("single_rf_we", 32'(rf_we), 32'd1);
      chk("single_rf_sel", 32'(rf_sel), 32'd5);
      chk("single_rf_wdata", 32'(rf_wdata), 32'hBEEF);
      chk("single_rf_wen", 32'(rf_wen), 32'b0010_0000);
      advance();
      @(negedge clk);
      chk("idle_rf_we", 32'(rf_we), 32'd0);
      chk("idle_rf_wen", 32'(rf_wen), 32'h00);
      reset = 1'b1;
      advance();
      reset = 1'b0;

      // round robin from rr_ptr = 0, one write per cycle
      drive(4'b1111, 1'b0);
      for (int k = 0; k < 8; k++) begin
         grant_check("rr_grant", 4'b0001 << (k % 4), 1);
         if (k > 0) chk("rr_rf_we", 32'(rf_we), 32'd1);
         advance();
      end

      // back-pressure: stage holds dest 3 while source 2 waits (rr_ptr = 0)
      set_src(SRC_ALU, 3'd3, 16'h3333);
      set_src(SRC_LINK, 3'd4, 16'h4444);
      drive(4'b0001, 1'b0);
      grant_check("hold_fill", 4'b0001, 1);
      advance();
      drive(4'b0100, 1'b1);
      for (int c = 0; c < 3; c++) begin
         grant_check("hold_ready", 4'b0000, 0);
         chk("hold_rf_sel", 32'(rf_sel), 32'd3);
         chk("hold_rf_we", 32'(rf_we), 32'd1);
         advance();
      end
      drive(4'b0100, 1'b0);
      grant_check("hold_release", 4'b0100, 1);
      advance();
      drive(4'b0000, 1'b0);
      @(negedge clk);
      chk("hold_next_sel", 32'(rf_sel), 32'd4);
      chk("hold_next_data", 32'(rf_wdata), 32'h4444);
      advance();

      // pointer skip: rr_ptr 3 -> grant 1 -> ptr 2 -> grant 0 -> ptr 1 -> grant 3
      drive(4'b0010, 1'b0);
      grant_check("skip_setup", 4'b0010, 1);
      advance();
      drive(4'b0001, 1'b0);
      grant_check("skip_src0", 4'b0001, 1);
      advance();
      drive(4'b1001, 1'b0);
      grant_check("skip_src3", 4'b1000, 1);
      advance();

      // reset while a write to R7 is held in the stage; it must never appear
      set_src(SRC_ALU, 3'd7, 16'h7777);
      drive(4'b0001, 1'b0);
      grant_check("r7_fill", 4'b0001, 0);
      advance();
      drive(4'b0000, 1'b1);
      @(negedge clk);
      chk("r7_held_sel", 32'(rf_sel), 32'd7);
      chk("r7_held_we", 32'(rf_we), 32'd1);
      advance();
      reset = 1'b1;
      grant_check("r7_reset_ready", 4'b0000, 0);
      advance();
      reset = 1'b0;
      drive(4'b0000, 1'b0);
      @(negedge clk);
      chk("r7_discard_we", 32'(rf_we), 32'd0);
      chk("r7_discard_wen", 32'(rf_wen), 32'h00);
      advance();
      advance();
      advance();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
